// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: load size encodings,
// exception/GPR limits and the MEM/WB pipeline register layout.
package wb_pkg;

  typedef enum logic [1:0] {
    MRT_BYTE = 2'b00,
    MRT_HALF = 2'b01,
    MRT_WORD = 2'b10,
    MRT_RSVD = 2'b11
  } mrt_size_e;

  localparam int         MRT_UNSIGNED_BIT = 2;
  localparam logic [3:0] EXC_NONE         = 4'd0;
  localparam logic [6:0] GPR_LIMIT        = 7'd32;

  typedef struct packed {
    logic        valid;
    logic        memtoreg;
    logic        regwrite;
    logic        hilo_we;
    logic [2:0]  rtype;
    logic [6:0]  waddr;
    logic [31:0] aluout;
    logic [31:0] memword;
    logic [63:0] hilo_data;
    logic [31:0] pc;
  } mw_reg_t;

endpackage

// File: rtl/load_align.sv
// Selects the byte/half/word addressed by a load from the raw 32-bit memory
// word and sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] i_memword,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_rtype,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_zext;

  assign w_zext = i_rtype[MRT_UNSIGNED_BIT];

  always_comb begin
    w_byte = i_memword[7:0];
    case (i_addr)
      2'd0: w_byte = i_memword[7:0];
      2'd1: w_byte = i_memword[15:8];
      2'd2: w_byte = i_memword[23:16];
      2'd3: w_byte = i_memword[31:24];
      default: w_byte = i_memword[7:0];
    endcase
  end

  // Misaligned halves trap upstream, so only addr[1] picks the lane.
  assign w_half = i_addr[1] ? i_memword[31:16] : i_memword[15:0];

  always_comb begin
    o_data = i_memword;
    case (mrt_size_e'(i_rtype[1:0]))
      MRT_BYTE: o_data = {{24{~w_zext & w_byte[7]}}, w_byte};
      MRT_HALF: o_data = {{16{~w_zext & w_half[15]}}, w_half};
      default:  o_data = i_memword;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load alignment, GPR and HI/LO commit.
// Optional trace ports are enabled by defining WB_TRACE_EN.
module wb_stage
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        aresetn,
  input  logic        stall,
  input  logic        flush,
  input  logic        MemtoRegW,
  input  logic        RegWriteW,
  input  logic        HI_LO_write_enableW,
  input  logic        is_ds_out,
  input  logic [31:0] ALUoutW,
  input  logic [31:0] Memdata,
  input  logic [2:0]  MemReadTypeW,
  input  logic [6:0]  WriteRegisterW,
  input  logic [63:0] HI_LO_dataW,
  input  logic [31:0] PCout,
  input  logic [3:0]  exception_out,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wb_valid
`ifdef WB_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  mw_reg_t     r_mw;
  mw_reg_t     w_mw_next;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_load;
  logic        w_hilo_live;
  logic        w_unused_ds;

  assign w_unused_ds = is_ds_out;

  // Pipeline advance: flush or stall loads a bubble; otherwise the MEM
  // instruction enters WB exactly once, on the cycle stall is low.
  always_comb begin
    w_mw_next = '0;
    if (!flush && !stall) begin
      w_mw_next.valid     = (exception_out == EXC_NONE);
      w_mw_next.memtoreg  = MemtoRegW;
      w_mw_next.regwrite  = RegWriteW;
      w_mw_next.hilo_we   = HI_LO_write_enableW;
      w_mw_next.rtype     = MemReadTypeW;
      w_mw_next.waddr     = WriteRegisterW;
      w_mw_next.aluout    = ALUoutW;
      w_mw_next.memword   = Memdata;
      w_mw_next.hilo_data = HI_LO_dataW;
      w_mw_next.pc        = PCout;
    end
  end

  assign w_hilo_live = r_mw.valid & r_mw.hilo_we;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_mw <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_mw <= w_mw_next;
      if (w_hilo_live) begin
        r_hi <= r_mw.hilo_data[63:32];
        r_lo <= r_mw.hilo_data[31:0];
      end
    end
  end

  load_align u_load_align (
    .i_memword (r_mw.memword),
    .i_addr    (r_mw.aluout[1:0]),
    .i_rtype   (r_mw.rtype),
    .o_data    (w_load)
  );

  assign rf_we    = r_mw.valid & r_mw.regwrite & (r_mw.waddr < GPR_LIMIT) &
                    (r_mw.waddr[4:0] != 5'd0);
  assign rf_waddr = r_mw.waddr[4:0];
  assign rf_wdata = r_mw.memtoreg ? w_load : r_mw.aluout;
  assign wb_valid = r_mw.valid;

  assign hi = w_hilo_live ? r_mw.hilo_data[63:32] : r_hi;
  assign lo = w_hilo_live ? r_mw.hilo_data[31:0]  : r_lo;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = r_mw.valid ? r_mw.pc : 32'd0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = r_mw.valid ? rf_waddr : 5'd0;
  assign debug_wb_rf_wdata = r_mw.valid ? rf_wdata : 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model of
// the write-back stage (slot contents, architectural HI/LO, load extraction).
module tb_wb_stage;

  localparam int W = 136;

  logic        clk = 1'b0;
  logic        aresetn, stall, flush;
  logic        MemtoRegW, RegWriteW, HI_LO_write_enableW, is_ds_out;
  logic [31:0] ALUoutW, Memdata, PCout;
  logic [2:0]  MemReadTypeW;
  logic [6:0]  WriteRegisterW;
  logic [63:0] HI_LO_dataW;
  logic [3:0]  exception_out;
  logic        rf_we, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi, lo;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .aresetn(aresetn), .stall(stall), .flush(flush),
    .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .HI_LO_write_enableW(HI_LO_write_enableW), .is_ds_out(is_ds_out),
    .ALUoutW(ALUoutW), .Memdata(Memdata), .MemReadTypeW(MemReadTypeW),
    .WriteRegisterW(WriteRegisterW), .HI_LO_dataW(HI_LO_dataW),
    .PCout(PCout), .exception_out(exception_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi(hi), .lo(lo), .wb_valid(wb_valid)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] a,
                                     input logic [2:0] t);
    logic [31:0] s;
    case (t[1:0])
      2'b00: begin
        s = (w >> (a * 8)) & 32'h0000_00FF;
        if (!t[2] && s[7]) s = s | 32'hFFFF_FF00;
      end
      2'b01: begin
        s = (w >> (a[1] * 16)) & 32'h0000_FFFF;
        if (!t[2] && s[15]) s = s | 32'hFFFF_0000;
      end
      default: s = w;
    endcase
    return s;
  endfunction

  // behavioural model: what sits in WB and the architectural HI/LO
  logic        m_valid, m_rw, m_m2r, m_hwe, m_rst;
  logic [2:0]  m_rt;
  logic [6:0]  m_wr;
  logic [31:0] m_alu, m_mem, m_pc, a_hi, a_lo;
  logic [63:0] m_hd;

  always @(posedge clk) begin
    logic        e_we;
    logic [31:0] e_wd, e_hi, e_lo, e_pc;
    if (!aresetn) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_hwe = 0; m_rt = 0; m_wr = 0;
      m_alu = 0; m_mem = 0; m_pc = 0; m_hd = 0; a_hi = 0; a_lo = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (m_valid && m_hwe) begin a_hi = m_hd[63:32]; a_lo = m_hd[31:0]; end
      if (flush || stall) begin
        m_valid = 0; m_rw = 0; m_hwe = 0;
      end else begin
        m_valid = (exception_out == 4'd0); m_rw = RegWriteW; m_m2r = MemtoRegW;
        m_hwe = HI_LO_write_enableW; m_rt = MemReadTypeW; m_wr = WriteRegisterW;
        m_alu = ALUoutW; m_mem = Memdata; m_pc = PCout; m_hd = HI_LO_dataW;
      end
    end
    e_we = m_valid && m_rw && (m_wr != 7'd0) && (m_wr < 7'd32);
    e_wd = m_m2r ? ld(m_mem, m_alu[1:0], m_rt) : m_alu;
    e_hi = (m_valid && m_hwe) ? m_hd[63:32] : a_hi;
    e_lo = (m_valid && m_hwe) ? m_hd[31:0] : a_lo;
    e_pc = m_valid ? m_pc : 32'd0;
    exp_q.push_back({(m_valid | m_rst), m_valid, e_we, m_wr[4:0], e_wd, e_hi, e_lo, e_pc});
  end

  // scoreboard compare, away from the active edge
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("wb_valid", 64'(wb_valid), 64'(e[134]));
      chk("rf_we", 64'(rf_we), 64'(e[133]));
      chk("hi", 64'(hi), 64'(e[95:64]));
      chk("lo", 64'(lo), 64'(e[63:32]));
      if (e[135]) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(e[132:128]));
        chk("rf_wdata", 64'(rf_wdata), 64'(e[127:96]));
      end
`ifdef WB_TRACE_EN
      chk("dbg_wen", 64'(debug_wb_rf_wen), 64'({4{e[133]}}));
      if (e[135]) begin
        chk("dbg_pc", 64'(debug_wb_pc), 64'(e[31:0]));
        chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(e[132:128]));
        chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(e[127:96]));
      end
`endif
    end
  end

  // driver tasks
  task automatic idle();
    stall = 0; flush = 0; MemtoRegW = 0; RegWriteW = 0; HI_LO_write_enableW = 0;
    is_ds_out = 0; ALUoutW = 0; Memdata = 0; MemReadTypeW = 3'b010;
    WriteRegisterW = 0; HI_LO_dataW = 0; PCout = 32'h1000; exception_out = 0;
  endtask

  task automatic instr(input logic [6:0] wr, input logic rw, input logic m2r,
                       input logic [2:0] rt, input logic [31:0] alu, input logic [31:0] md,
                       input logic hwe, input logic [63:0] hd, input logic [3:0] exc);
    WriteRegisterW = wr; RegWriteW = rw; MemtoRegW = m2r; MemReadTypeW = rt;
    ALUoutW = alu; Memdata = md; HI_LO_write_enableW = hwe; HI_LO_dataW = hd;
    exception_out = exc; PCout = PCout + 32'd4;
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    aresetn = 0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);

    // load extraction
    @(negedge clk); aresetn = 1;
    instr(7'd5, 1, 1, 3'b000, 32'h1, 32'h8899AABB, 0, 64'd0, 4'd0);
    settle();
    chk("lb_we", 64'(rf_we), 64'd1);
    chk("lb_waddr", 64'(rf_waddr), 64'd5);
    chk("lb_data", 64'(rf_wdata), 64'hFFFFFFAA);
    @(negedge clk); instr(7'd5, 1, 1, 3'b101, 32'h2, 32'h8899AABB, 0, 64'd0, 4'd0);
    settle();
    chk("lhu_data", 64'(rf_wdata), 64'h00008899);
    @(negedge clk); instr(7'd5, 1, 1, 3'b010, 32'h0, 32'h8899AABB, 0, 64'd0, 4'd0);
    settle();
    chk("lw_data", 64'(rf_wdata), 64'h8899AABB);

    // stall: commit exactly once after stall falls
    @(negedge clk); instr(7'd7, 1, 0, 3'b010, 32'h77, 32'h0, 0, 64'd0, 4'd0); stall = 1;
    repeat (3) begin settle(); chk("stall_we", 64'(rf_we), 64'd0); end
    @(negedge clk); stall = 0;
    settle();
    chk("unstall_we", 64'(rf_we), 64'd1);
    chk("unstall_waddr", 64'(rf_waddr), 64'd7);
`ifdef WB_TRACE_EN
    chk("unstall_dbg_wen", 64'(debug_wb_rf_wen), 64'hF);
`endif
    @(negedge clk); idle();
    settle();
    chk("after_we", 64'(rf_we), 64'd0);

    // HI/LO bypass, retention, exception suppression
    @(negedge clk); instr(7'd0, 0, 0, 3'b010, 32'h0, 32'h0, 1, 64'h11112222_33334444, 4'd0);
    settle();
    chk("hilo_byp_hi", 64'(hi), 64'h11112222);
    chk("hilo_byp_lo", 64'(lo), 64'h33334444);
    @(negedge clk); idle();
    settle();
    chk("hilo_keep_hi", 64'(hi), 64'h11112222);
    @(negedge clk); instr(7'd3, 1, 0, 3'b010, 32'h5, 32'h0, 1, 64'h55556666_77778888, 4'd4);
    settle();
    chk("exc_we", 64'(rf_we), 64'd0);
    chk("exc_hi", 64'(hi), 64'h11112222);
    @(negedge clk); idle();
    settle();
    chk("exc_hi_after", 64'(hi), 64'h11112222);

    // non-committing destinations
    @(negedge clk); instr(7'd0, 1, 0, 3'b010, 32'h1, 32'h0, 0, 64'd0, 4'd0);
    settle();
    chk("r0_we", 64'(rf_we), 64'd0);
    @(negedge clk); instr(7'd40, 1, 0, 3'b010, 32'h1, 32'h0, 0, 64'd0, 4'd0);
    settle();
    chk("w40_we", 64'(rf_we), 64'd0);
    chk("w40_valid", 64'(wb_valid), 64'd1);

    // flush kills the incoming instruction, not the one in WB
    @(negedge clk); instr(7'd6, 1, 0, 3'b010, 32'h66, 32'h0, 0, 64'd0, 4'd0);
    settle();
    @(negedge clk); instr(7'd4, 1, 0, 3'b010, 32'h44, 32'h0, 0, 64'd0, 4'd0); flush = 1;
    #1;
    chk("flush_cur_we", 64'(rf_we), 64'd1);
    chk("flush_cur_waddr", 64'(rf_waddr), 64'd6);
    settle();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_we", 64'(rf_we), 64'd0);

    // reset during a stall discards the pending instruction
    @(negedge clk); flush = 0;
    instr(7'd9, 1, 0, 3'b010, 32'h99, 32'h0, 0, 64'd0, 4'd0); stall = 1;
    settle();
    chk("rs_stall_we", 64'(rf_we), 64'd0);
    @(negedge clk); aresetn = 0;
    settle();
    chk("rs_we", 64'(rf_we), 64'd0);
    chk("rs_waddr", 64'(rf_waddr), 64'd0);
    chk("rs_wdata", 64'(rf_wdata), 64'd0);
    chk("rs_hi", 64'(hi), 64'd0);
    chk("rs_lo", 64'(lo), 64'd0);
    chk("rs_valid", 64'(wb_valid), 64'd0);
    @(negedge clk); aresetn = 1; idle();
    settle();
    chk("rs_nocommit", 64'(rf_we), 64'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      aresetn = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      MemtoRegW = $urandom_range(0, 1) == 1;
      RegWriteW = $urandom_range(0, 3) != 0;
      HI_LO_write_enableW = ($urandom_range(0, 4) == 0);
      is_ds_out = $urandom_range(0, 1) == 1;
      ALUoutW = $urandom;
      Memdata = $urandom;
      MemReadTypeW = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      WriteRegisterW = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(32, 127))
                                                   : 7'($urandom_range(0, 31));
      HI_LO_dataW = {$urandom, $urandom};
      PCout = $urandom;
      exception_out = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    end

    @(negedge clk); aresetn = 1; idle();
    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
